// File: rtl/vram_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals for the VRAM port arbiter.
// Latency: none, this is wiring only.
// Backpressure: req_ready carries the per-requester stall; responses and memory side cannot stall.
interface vram_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic [2:0]         owner;
    logic               locked;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_last, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               owner, locked
    );

    // Requester / memory environment side
    modport master (
        output req_valid, req_we, req_last, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               owner, locked
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one VRAM port: requester 0 wins at burst boundaries, others round-robin, bursts lock the port.
// Latency: handshake to mem_en 1 cycle; read handshake to rsp_valid RD_LAT+1 cycles.
// Backpressure: combinational req_ready, only the lock owner is served while locked; responses never stall.
module vram_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    vram_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      owner_q, owner_nxt;
    logic [2:0]      rr, rr_nxt;
    logic [NREQ-1:0] ready;
    logic [2:0]      gnt;
    logic            gnt_vld;
    int              cand;
    logic            accept;
    logic [2:0]      acc_id;

    logic            mem_en_q, mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [2:0]      mem_id_q;

    logic [RD_LAT-1:0] pv;
    logic [2:0]        pid [RD_LAT];

    // Grant candidate: requester 0 first, then round-robin over 1..NREQ-1 starting at rr.
    always_comb begin
        gnt     = 3'd0;
        gnt_vld = 1'b0;
        cand    = 0;
        if (bus.req_valid[0]) begin
            gnt_vld = 1'b1;
        end else begin
            for (int j = 0; j < NREQ - 1; j++) begin
                cand = int'(rr) + j;
                if (cand > NREQ - 1) cand = cand - (NREQ - 1);
                if (!gnt_vld && bus.req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt     = 3'(cand);
                end
            end
        end
    end

    // Ready generation, lock tracking and round-robin pointer update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner_q;
        rr_nxt    = rr;
        ready     = '0;
        acc_id    = owner_q;
        if (state == IDLE) begin
            if (gnt_vld) begin
                ready[gnt] = 1'b1;
                acc_id     = gnt;
            end
        end else begin
            ready[owner_q] = 1'b1;
        end
        // Nothing is accepted while reset is held.
        if (!reset_reset_n) ready = '0;
        accept = |(ready & bus.req_valid);
        if (accept) begin
            if (state == IDLE) begin
                owner_nxt = acc_id;
                cnt_nxt   = CW'(1);
                if (acc_id != 3'd0) rr_nxt = (acc_id == 3'(NREQ - 1)) ? 3'd1 : acc_id + 3'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
            // A full-length burst releases even without req_last so others are not starved.
            if (bus.req_last[acc_id] || cnt_nxt == CW'(MAX_BURST)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = BURST;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_q <= 3'd0;
            rr      <= 3'd1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner_q <= owner_nxt;
            rr      <= rr_nxt;
        end
    end

    // Register the accepted beat onto the memory port.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_id_q    <= 3'd0;
        end else begin
            mem_en_q <= accept;
            mem_we_q <= accept & bus.req_we[acc_id];
            if (accept) begin
                mem_addr_q  <= bus.req_addr[acc_id*AW +: AW];
                mem_wdata_q <= bus.req_wdata[acc_id*DW +: DW];
                mem_id_q    <= acc_id;
            end
        end
    end

    // Read tag pipeline, aligned so the last slot matures with valid mem_rdata.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) pid[i] <= 3'd0;
        end else begin
            pv[0]  <= mem_en_q & ~mem_we_q;
            pid[0] <= mem_id_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]  <= pv[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = pv[RD_LAT-1] ? (NREQ'(1) << pid[RD_LAT-1]) : '0;
    assign bus.rsp_rdata = pv[RD_LAT-1] ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = (state == BURST);
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for the VRAM port arbiter: directed scenarios plus random traffic against a transaction model.
// Latency: model predicts mem_* one cycle and rsp_valid RD_LAT+1 cycles after each accepted beat.
// Backpressure: inputs are driven freely; acceptance is predicted from the arbitration rules.
module tb_vram_port_arbiter;
    localparam int NREQ      = 3;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 8;
    localparam int VW        = 2*NREQ + DW + 2 + AW + DW + 3 + 1;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b0;
    always #5 clk_clk = ~clk_clk;

    vram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    vram_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .bus          (bus)
    );

    // Memory content is a fixed function of the address; 0x0040 holds 0xBEEF.
    function automatic logic [DW-1:0] mem_func(input logic [AW-1:0] a);
        return a ^ 16'hBEAF;
    endfunction

    // Memory macro: read data appears RD_LAT cycles after mem_en.
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk_clk) begin
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_func(bus.mem_addr) : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    // Transaction-level reference model state.
    typedef struct { int due; int id; logic [AW-1:0] addr; } rsp_t;
    rsp_t rq [$];
    int   m_lock, m_beats, m_rr, m_owner, cyc;
    logic            e_en, e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata, e_rdata;
    logic [NREQ-1:0] e_rsp;
    int   vecs = 0;
    int   errs = 0;

    task automatic model_reset();
        m_lock = -1; m_beats = 0; m_rr = 1; m_owner = 0; cyc = 0;
        rq.delete();
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_rsp = '0;
    endtask

    // Which requester the rules say may transfer this cycle.
    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int k;
        r = '0;
        if (!reset_reset_n) return r;
        if (m_lock >= 0) r[m_lock] = 1'b1;
        else if (bus.req_valid[0]) r[0] = 1'b1;
        else begin
            for (int j = 0; j < NREQ - 1; j++) begin
                k = (m_rr - 1 + j) % (NREQ - 1) + 1;
                if (bus.req_valid[k]) begin
                    r[k] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Advance the model by one clock using the inputs held this cycle.
    task automatic model_step();
        logic [NREQ-1:0] acc;
        int k;
        acc = model_ready() & bus.req_valid;
        e_en = 0; e_we = 0;
        if (acc != '0) begin
            k = 0;
            for (int i = 0; i < NREQ; i++) if (acc[i]) k = i;
            e_en    = 1;
            e_we    = bus.req_we[k];
            e_addr  = bus.req_addr[k*AW +: AW];
            e_wdata = bus.req_wdata[k*DW +: DW];
            if (!bus.req_we[k]) rq.push_back('{cyc + RD_LAT + 1, k, e_addr});
            if (m_lock < 0) begin
                m_beats = 0;
                if (k != 0) m_rr = k % (NREQ - 1) + 1;
            end
            m_beats++;
            m_owner = k;
            m_lock  = (bus.req_last[k] || m_beats == MAX_BURST) ? -1 : k;
            if (m_lock < 0) m_beats = 0;
        end
        cyc++;
        e_rsp = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rsp[rq[0].id] = 1'b1;
            e_rdata = mem_func(rq[0].addr);
            void'(rq.pop_front());
        end
    endtask

    function automatic logic [VW-1:0] obs_vec();
        logic [DW-1:0] rd, wd;
        logic [AW-1:0] ad;
        logic          we;
        rd = (e_rsp != '0) ? bus.rsp_rdata : '0;
        we = e_en ? bus.mem_we : 1'b0;
        ad = e_en ? bus.mem_addr : '0;
        wd = e_en ? bus.mem_wdata : '0;
        return {bus.req_ready & bus.req_valid, bus.rsp_valid, rd, bus.mem_en, we, ad, wd,
                bus.owner, bus.locked};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [DW-1:0] rd, wd;
        logic [AW-1:0] ad;
        logic          we, lk;
        rd = (e_rsp != '0) ? e_rdata : '0;
        we = e_en ? e_we : 1'b0;
        ad = e_en ? e_addr : '0;
        wd = e_en ? e_wdata : '0;
        lk = (m_lock >= 0);
        return {model_ready() & bus.req_valid, e_rsp, rd, e_en, we, ad, wd, 3'(m_owner), lk};
    endfunction

    task automatic advance();
        @(posedge clk_clk);
        model_step();
        #1;
    endtask

    task automatic clear_all();
        bus.req_valid = '0; bus.req_we = '0; bus.req_last = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic last,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i] = v; bus.req_we[i] = we; bus.req_last[i] = last;
        bus.req_addr[i*AW +: AW] = a; bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        clear_all();
        set_req(0, 1, 1, 1, 16'h1111, 16'h2222);
        set_req(1, 1, 0, 1, 16'h1234, 16'h0000);
        #12;
        vecs++; if (bus.req_ready !== '0) begin errs++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
        vecs++; if ({bus.rsp_valid, bus.mem_en, bus.mem_we, bus.locked} !== '0) begin
            errs++; $display("FAIL reset_ctl got rsp=%b en=%b we=%b lk=%b exp=0", bus.rsp_valid, bus.mem_en, bus.mem_we, bus.locked); end
        vecs++; if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
            errs++; $display("FAIL reset_bus got addr=%h wdata=%h exp=0", bus.mem_addr, bus.mem_wdata); end
        vecs++; if (bus.owner !== 3'd0) begin errs++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
        clear_all();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        model_reset();
        advance();
    endtask

    task automatic test_single_read();
        clear_all();
        set_req(1, 1, 0, 1, 16'h0040, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL single_read cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (c == 1) begin
                vecs++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 16'h0040}) begin
                    errs++; $display("FAIL single_read_mem got en=%b we=%b addr=%h exp en=1 we=0 addr=0040", bus.mem_en, bus.mem_we, bus.mem_addr); end
            end
            if (c == 3) begin
                vecs++; if ({bus.rsp_valid, bus.rsp_rdata} !== {3'b010, 16'hBEEF}) begin
                    errs++; $display("FAIL single_read_rsp got v=%b d=%h exp v=010 d=beef", bus.rsp_valid, bus.rsp_rdata); end
            end
            advance();
            clear_all();
        end
    endtask

    task automatic test_priority();
        int seq [4] = '{2, 1, 2, 1};
        logic [NREQ-1:0] want;
        for (int c = 0; c < 8; c++) begin
            clear_all();
            for (int i = (c < 4 ? 0 : 1); i < NREQ; i++) set_req(i, 1, 1, 1, AW'($urandom), DW'($urandom));
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            want = '0;
            if (c < 4) want[0] = 1'b1; else want[seq[c-4]] = 1'b1;
            vecs++; if (bus.req_ready !== want) begin errs++; $display("FAIL priority_order step=%0d got=%b exp=%b", c, bus.req_ready, want); end
            advance();
        end
        clear_all();
    endtask

    task automatic test_burst_lock();
        for (int c = 0; c < 5; c++) begin
            clear_all();
            if (c < 3) set_req(2, 1, 1, (c == 2), AW'(16'h0500 + c), DW'($urandom));
            if (c >= 1 && c <= 3) set_req(0, 1, 1, 1, 16'h0600, 16'hA0A0);
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL burst_lock cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (c < 3) begin
                vecs++; if (bus.req_ready !== 3'b100) begin errs++; $display("FAIL burst_lock_ready step=%0d got=%b exp=100", c, bus.req_ready); end
            end
            if (c == 1 || c == 2) begin
                vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL burst_lock_locked step=%0d got=%b exp=1", c, bus.locked); end
            end
            if (c == 3) begin
                vecs++; if (bus.req_ready !== 3'b001) begin errs++; $display("FAIL burst_lock_release got=%b exp=001", bus.req_ready); end
            end
            advance();
        end
        clear_all();
    endtask

    task automatic test_forced_release();
        int n1 = 0;
        bit done2 = 0;
        logic [NREQ-1:0] acc;
        for (int c = 0; c < 14; c++) begin
            clear_all();
            if (n1 < 11) set_req(1, 1, 1, (n1 == 10), AW'(16'h0200 + n1), DW'($urandom));
            if (c >= 1 && !done2) set_req(2, 1, 1, 1, 16'h0300, 16'h5555);
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL forced_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (c == 7) begin
                vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL forced_release_lock got=%b exp=1", bus.locked); end
            end
            if (c == 8) begin
                vecs++; if ({bus.req_ready, bus.locked} !== {3'b100, 1'b0}) begin
                    errs++; $display("FAIL forced_release_rearb got ready=%b lk=%b exp ready=100 lk=0", bus.req_ready, bus.locked); end
            end
            acc = model_ready() & bus.req_valid;
            if (acc[1]) n1++;
            if (acc[2]) done2 = 1;
            advance();
        end
        clear_all();
    endtask

    task automatic test_response_routing();
        logic [AW-1:0]   adr  [3] = '{16'h0A00, 16'h0B00, 16'h0C00};
        int              who  [3] = '{1, 2, 1};
        logic [NREQ-1:0] want;
        for (int c = 0; c < 7; c++) begin
            clear_all();
            if (c < 3) set_req(who[c], 1, 0, 1, adr[c], 16'h0000);
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL rsp_routing cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (c >= 3 && c <= 5) begin
                want = '0; want[who[c-3]] = 1'b1;
                vecs++; if ({bus.rsp_valid, bus.rsp_rdata} !== {want, mem_func(adr[c-3])}) begin
                    errs++; $display("FAIL rsp_routing_onehot step=%0d got v=%b d=%h exp v=%b d=%h",
                                     c, bus.rsp_valid, bus.rsp_rdata, want, mem_func(adr[c-3])); end
            end
            advance();
        end
        clear_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_all();
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 99) < (i == 0 ? 25 : 60))
                    set_req(i, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            advance();
        end
        // Close any open lock and drain outstanding reads.
        for (int c = 0; c < 12; c++) begin
            clear_all();
            if (m_lock >= 0) set_req(m_lock, 1, 1, 1, 16'h0F00, 16'h0F0F);
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            advance();
        end
        clear_all();
    endtask

    task automatic test_reset_mid_burst();
        clear_all();
        for (int c = 0; c < 2; c++) begin
            set_req(1, 1, 0, 0, AW'(16'h0100 + c), 16'h0000);
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            advance();
        end
        vecs++; if (bus.locked !== 1'b1) begin errs++; $display("FAIL reset_mid_locked got=%b exp=1", bus.locked); end
        set_req(1, 1, 0, 1, 16'h0700, 16'h0000);
        set_req(2, 1, 0, 1, 16'h0800, 16'h0000);
        #2;
        reset_reset_n = 1'b0;
        #1;
        vecs++; if (bus.req_ready !== '0) begin errs++; $display("FAIL reset_mid_ready got=%b exp=000", bus.req_ready); end
        vecs++; if ({bus.rsp_valid, bus.mem_en, bus.locked, bus.owner} !== '0) begin
            errs++; $display("FAIL reset_mid_outputs got rsp=%b en=%b lk=%b own=%0d exp=0", bus.rsp_valid, bus.mem_en, bus.locked, bus.owner); end
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        model_reset();
        reset_reset_n = 1'b1;
        #1;
        vecs++; if (bus.req_ready !== 3'b010) begin errs++; $display("FAIL reset_mid_first_grant got=%b exp=010", bus.req_ready); end
        vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
        advance();
        for (int c = 1; c < 7; c++) begin
            clear_all();
            @(negedge clk_clk);
            vecs++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (c <= 2) begin
                vecs++; if (bus.rsp_valid !== '0) begin errs++; $display("FAIL reset_mid_stale_rsp step=%0d got=%b exp=000", c, bus.rsp_valid); end
            end
            advance();
        end
    endtask

    initial begin
        clear_all();
        model_reset();
        test_reset();
        test_single_read();
        test_priority();
        test_burst_lock();
        test_forced_release();
        test_response_routing();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
